// File: rtl/bc_tx_arbiter_pkg.sv
// bc_pkg: shared constants and FSM state type for the command-buffer transmit arbiter.
package bc_pkg;
    localparam int BC_DATA_W = 16;
    localparam int BC_TRUNC_W = 8;
    typedef enum logic {IDLE, GRANT} bc_state_e;
endpackage

// File: rtl/bc_tx_arbiter_if.sv
// bc_tx_arbiter_if: requester-side and buffer-side ready/valid signals of the arbiter.
interface bc_tx_arbiter_if import bc_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = BC_DATA_W
) ();
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_rdy;
    logic out_valid;
    logic [DATA_W-1:0] out_data;
    logic out_rdy;
    modport master (output req_valid, req_data, req_last, out_rdy, input req_rdy, out_valid, out_data);
    modport slave (input req_valid, req_data, req_last, out_rdy, output req_rdy, out_valid, out_data);
endinterface

// File: rtl/bc_tx_arbiter_rr_pick.sv
// bc_rr_pick: combinational round-robin winner select with an absolute-priority E-stop index.
module bc_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ESTOP_IDX = 0,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      rr_ptr,
    output logic [GW-1:0]      winner,
    output logic               any_req
);
    logic [GW-1:0] idx;
    // Scan farthest-first so the nearest requester after rr_ptr is the last write.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
            winner = req[idx] ? idx : winner;
        end
        winner = req[ESTOP_IDX] ? GW'(ESTOP_IDX) : winner;
    end
    assign any_req = |req;
endmodule

// File: rtl/bc_tx_arbiter.sv
// bc_tx_arbiter: burst-locked round-robin arbiter with E-stop priority feeding the buffer ctrl_in port.
module bc_tx_arbiter import bc_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = BC_DATA_W,
    parameter int MAX_BURST = 8,
    parameter int ESTOP_IDX = 0,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    bc_tx_arbiter_if.slave        bus,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic [BC_TRUNC_W-1:0] trunc_cnt
);
    bc_state_e state;
    logic [GW-1:0] rr_ptr, winner;
    logic [7:0] beat_cnt;
    logic any_req, xfer, last, at_max;
    logic [DATA_W-1:0] dv [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_dv
        assign dv[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    bc_rr_pick #(.NUM_REQ(NUM_REQ), .ESTOP_IDX(ESTOP_IDX)) u_pick (
        .req(bus.req_valid), .rr_ptr(rr_ptr), .winner(winner), .any_req(any_req)
    );

    assign bus.out_valid = (state == GRANT) && bus.req_valid[grant_id];
    assign bus.out_data = dv[grant_id];
    assign bus.req_rdy = (state == GRANT) ? NUM_REQ'(bus.out_rdy) << grant_id : '0;
    assign xfer = bus.out_valid && bus.out_rdy;
    assign last = bus.req_last[grant_id];
    assign at_max = beat_cnt == 8'(MAX_BURST - 1);

    // E-stop grants leave rr_ptr alone so fairness among the others is undisturbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy <= 1'b0;
            grant_id <= '0;
            beat_cnt <= '0;
            rr_ptr <= GW'(NUM_REQ - 1);
            trunc_cnt <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                state <= GRANT;
                busy <= 1'b1;
                grant_id <= winner;
                beat_cnt <= '0;
                if (winner != GW'(ESTOP_IDX)) rr_ptr <= winner;
            end
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last || at_max) begin
                state <= IDLE;
                busy <= 1'b0;
            end
            if (!last && at_max && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bc_tx_arbiter.sv
// tb_bc_tx_arbiter: directed checks of arbitration order, E-stop priority, truncation, backpressure and async reset.
module tb_bc_tx_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] grant_id;
    logic busy;
    logic [7:0] trunc_cnt;

    bc_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(16)) bus ();
    bc_tx_arbiter #(.NUM_REQ(N), .DATA_W(16), .MAX_BURST(8), .ESTOP_IDX(0)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .grant_id(grant_id), .busy(busy), .trunc_cnt(trunc_cnt)
    );

    always #5 clk = ~clk;

    logic [16:0] beats [N][64];
    int head [N];
    int tail [N];
    logic fire [N];
    logic [15:0] log_data [256];
    logic [1:0] log_id [256];
    int log_cyc [256];
    int log_n = 0;
    int cyc = 0;
    logic [3:0] rdy_pat = 4'b1111;
    logic stall_prev = 1'b0;
    logic [15:0] data_prev = '0;
    int n_chk = 0;
    int n_fail = 0;
    int base;
    logic [15:0] e3_data [7] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'hDEAD, 16'h0300, 16'h0150};
    logic [1:0] e3_id [7] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(int r, logic [15:0] d, logic l);
        beats[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = head[i] < tail[i];
            {bus.req_last[i], bus.req_data[i*16 +: 16]} = (head[i] < tail[i]) ? beats[i][head[i]] : 17'd0;
        end
        bus.out_rdy = rdy_pat[cyc % 4];
    endtask

    task automatic step(bit do_rst = 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (fire[i]) head[i]++;
        drive();
        if (do_rst) begin
            #1 rst = 1'b0;
            #1 chk("rst_async", {bus.out_valid, busy, bus.req_rdy}, 0);
            rst = 1'b1;
            for (int i = 0; i < N; i++) head[i] = tail[i];
            drive();
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) fire[i] = bus.req_valid[i] & bus.req_rdy[i];
        if (stall_prev && bus.out_valid) chk("stall_hold", bus.out_data, data_prev);
        stall_prev = bus.out_valid & ~bus.out_rdy;
        data_prev = bus.out_data;
        if (bus.out_valid && bus.out_rdy) begin
            log_data[log_n] = bus.out_data;
            log_id[log_n] = grant_id;
            log_cyc[log_n] = cyc;
            log_n++;
        end
        cyc++;
    endtask

    task automatic run_until(int n, int budget);
        for (int k = 0; k < budget && log_n < n; k++) step();
        chk("progress", log_n, n);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            fire[i] = 1'b0;
        end
        drive();
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        // idle after reset
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t1_idle", {bus.out_valid, bus.req_rdy, busy, grant_id, trunc_cnt}, 0);
        end
        // round-robin 1,2,3 with one bubble between bursts
        for (int r = 1; r <= 3; r++)
            for (int b = 0; b < 3; b++) push(r, 16'h0100 + 16'(r * 16 + b), b == 2);
        run_until(9, 60);
        for (int b = 0; b < 9; b++) begin
            chk("t2_id", log_id[b], 1 + b / 3);
            chk("t2_data", log_data[b], 16'h0100 + 16'((1 + b / 3) * 16 + b % 3));
        end
        chk("t2_back2back", log_cyc[1] - log_cyc[0], 1);
        chk("t2_gap12", log_cyc[3] - log_cyc[2], 2);
        chk("t2_gap23", log_cyc[6] - log_cyc[5], 2);
        push(1, 16'h0111, 1'b1);
        push(2, 16'h0122, 1'b1);
        push(3, 16'h0133, 1'b1);
        run_until(12, 40);
        chk("t2_wrap1", log_id[9], 1);
        chk("t2_wrap2", log_id[10], 2);
        chk("t2_wrap3", log_id[11], 3);
        // E-stop arrives mid-burst, does not disturb rr_ptr
        base = log_n;
        for (int b = 0; b < 4; b++) push(2, 16'h0200 + 16'(b), b == 3);
        run_until(base + 1, 20);
        push(0, 16'hDEAD, 1'b1);
        push(3, 16'h0300, 1'b1);
        push(1, 16'h0150, 1'b1);
        run_until(base + 7, 60);
        for (int b = 0; b < 7; b++) begin
            chk("t3_id", log_id[base + b], e3_id[b]);
            chk("t3_data", log_data[base + b], e3_data[b]);
        end
        repeat (3) step();
        chk("t3_idle_hold", {busy, grant_id}, 1);
        // truncation at MAX_BURST, remainder on next grant
        base = log_n;
        for (int b = 0; b < 12; b++) push(1, 16'h0400 + 16'(b), b == 11);
        run_until(base + 12, 80);
        for (int b = 0; b < 12; b++) chk("t4_data", {log_id[base + b], log_data[base + b]}, {2'd1, 16'h0400 + 16'(b)});
        chk("t4_gap", log_cyc[base + 8] - log_cyc[base + 7], 2);
        chk("t4_trunc", trunc_cnt, 1);
        // last coinciding with the limit is a normal release
        base = log_n;
        for (int b = 0; b < 8; b++) push(3, 16'h0700 + 16'(b), b == 7);
        run_until(base + 8, 40);
        repeat (2) step();
        chk("t4_exact8", trunc_cnt, 1);
        chk("t4_exact8_id", log_id[base + 7], 3);
        // backpressure
        base = log_n;
        rdy_pat = 4'b1001;
        for (int b = 0; b < 4; b++) push(2, 16'h0500 + 16'(b), b == 3);
        run_until(base + 4, 40);
        for (int b = 0; b < 4; b++) chk("t5_data", log_data[base + b], 16'h0500 + 16'(b));
        repeat (4) step();
        chk("t5_count", log_n, base + 4);
        rdy_pat = 4'b1111;
        // async reset during beat 2, arbitration restarts with index 0 first
        repeat (3) step();
        base = log_n;
        for (int b = 0; b < 5; b++) push(1, 16'h0600 + 16'(b), b == 4);
        run_until(base + 1, 20);
        step(1'b1);
        chk("t6_post", {busy, grant_id, trunc_cnt}, 0);
        push(2, 16'h0620, 1'b1);
        push(1, 16'h0610, 1'b1);
        run_until(base + 3, 30);
        chk("t6_first", {log_id[base + 1], log_data[base + 1]}, {2'd1, 16'h0610});
        chk("t6_second", {log_id[base + 2], log_data[base + 2]}, {2'd2, 16'h0620});
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/bc_tx_arbiter.md
Name: bc_tx_arbiter

Overview:
- Shares the single 16-bit ready/valid write channel of the bidirectional command buffer (ctrl_in side) among NUM_REQ command sources, e.g. emergency-stop logic, the avoidance planner, manual override and telemetry.
- Grants are burst-locked: a winner keeps the channel until its last beat or until MAX_BURST beats.
- Arbitration is round-robin, except the E-stop source wins whenever it is requesting at an arbitration point.
- Sits directly upstream of the buffer's ctrl_in port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, beat width; matches the buffer data width.
- MAX_BURST, 8, maximum beats per grant before forced release (1..255).
- ESTOP_IDX, 0, index of the priority requester.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester beat valid.
- req_data, in, NUM_REQ*DATA_W, requester i occupies bits [i*DATA_W +: DATA_W].
- req_last, in, NUM_REQ, marks the final beat of a requester's burst.
- req_rdy, out, NUM_REQ, per-requester ready.
- out_valid, out, 1, beat valid to the buffer (ctrl_in_valid).
- out_data, out, DATA_W, beat to the buffer (ctrl_in_data).
- out_rdy, in, 1, buffer ready (ctrl_in_rdy).
- grant_id, out, $clog2(NUM_REQ), current/last granted index.
- busy, out, 1, high while in GRANT.
- trunc_cnt, out, 8, saturating count of bursts cut off at MAX_BURST.

Behaviour:
Reset (rst low, any time, asynchronous):
- state=IDLE; out_valid=0; req_rdy=0; busy=0; grant_id=0; trunc_cnt=0; beat_cnt=0.
- rr_ptr = NUM_REQ-1, so index 0 has first round-robin priority.
- Reset asserted mid-burst abandons the burst; no partial state survives.

State machine, IDLE / GRANT:
- IDLE:
  - out_valid=0, all req_rdy=0.
  - If any req_valid: if req_valid[ESTOP_IDX], winner=ESTOP_IDX; otherwise winner is the first set req_valid searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register grant_id=winner and beat_cnt=0, then go to GRANT next cycle.
  - rr_ptr<=winner only when winner != ESTOP_IDX. E-stop grants do not disturb fairness.
- GRANT (combinational pass-through, zero added latency per beat):
  - out_valid=req_valid[g]; out_data=req_data[g]; req_rdy[g]=out_rdy; req_rdy of all others = 0.
  - A beat transfers on out_valid && out_rdy; beat_cnt increments on each transfer.
  - Release when a transfer has req_last[g]=1 -> IDLE.
  - Release when a transfer occurs with beat_cnt==MAX_BURST-1 and req_last[g]=0 -> IDLE, trunc_cnt++ (saturates at 255).
  - If req_last and the MAX_BURST limit coincide on the same beat, it is a normal release with no truncation count.
  - req_valid[g] dropping mid-burst: hold the grant and wait indefinitely; no timeout.
  - out_rdy low (buffer full): hold the grant; out_data stable as long as the requester holds its data.
- Latency:
  - Earliest first beat is 1 cycle after req_valid is seen in IDLE.
  - One mandatory IDLE bubble between consecutive bursts.
- No preemption: E-stop waits for the current burst to end, which is bounded by MAX_BURST beats plus buffer stalls.
- busy=1 exactly in GRANT. grant_id holds its value in IDLE.

Decomposition:
- Package bc_pkg: BC_DATA_W=16, state enum {IDLE, GRANT}, trunc counter width constant.
- Sub-module bc_rr_pick:
  - Purely combinational.
  - Inputs: request vector, rr_ptr, ESTOP_IDX.
  - Outputs: winner index, any_req.
  - Can be verified standalone.

Test Plan:
1. Reset/idle: rst low then high, all req_valid=0 -> out_valid=0, req_rdy=0, busy=0, grant_id=0, trunc_cnt=0 for 20 cycles.
2. Round-robin: requesters 1,2,3 each send a 3-beat burst (data 0x0100+i..), out_rdy=1 -> bursts appear in order 1,2,3, each 3 beats, with 1 idle cycle between bursts; with all requesting again, the next grant goes to 1 (wrap), never repeating 3.
3. E-stop priority: requester 2 is mid-burst when req_valid[0] rises with 1 beat 0xDEAD -> 2's burst completes, then grant_id=0 and 0xDEAD is output; rr_ptr is still 2, so the following grant goes to 3 if it is requesting.
4. Truncation: MAX_BURST=8, requester 1 sends 12 beats with last only on beat 12 -> release after beat 8, trunc_cnt=1; the remaining 4 beats go out on 1's next grant.
5. Backpressure: out_rdy toggles 1,0,0,1 during a 4-beat burst -> no beat lost or duplicated; out_data stable while out_rdy=0; the buffer read side returns the exact sequence.
6. Async reset mid-burst: rst low for 1 ns (not clock-aligned) during beat 2 of 5 -> out_valid=0 and busy=0 immediately; after release, arbitration restarts with index 0 first.
